// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Single-port data-memory arbiter between the MEM pipeline
//                stage (priority) and the external host port. A saturating
//                starvation counter forces the host through after
//                STARVE_MAX consecutive denied cycles. Read data is routed
//                back to the requester that issued the read, one cycle
//                after the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              srst,

    // MEM-stage requester
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    // Host requester
    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,

    // Data SRAM
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter compare value, sized to the 4-bit starvation counter.
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    // Read-owner encoding stored in rd_owner.
    localparam logic c_OWNER_CPU = 1'b0;
    localparam logic c_OWNER_EXT = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rd_pend_q,    rd_pend_d;
    logic       rd_owner_q,   rd_owner_d;

    // ------------------------------------------------------------------------
    // Combinational grant / datapath signals
    // ------------------------------------------------------------------------
    logic w_force_ext;   // host has waited long enough and must win
    logic w_cpu_gnt;
    logic w_ext_gnt;
    logic w_rd_grant;    // a read is being granted this cycle
    logic w_rd_cpu;      // a CPU read return is being presented
    logic w_rd_ext;      // a host read return is being presented

    // Grant decision: forced host first, then CPU, then host; nothing in reset.
    always_comb begin
        w_force_ext = ext_req & (starve_cnt_q == c_STARVE_MAX);
        w_cpu_gnt   = 1'b0;
        w_ext_gnt   = 1'b0;
        if (!srst) begin
            if (w_force_ext) begin
                w_ext_gnt = 1'b1;
            end else if (cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else if (ext_req) begin
                w_ext_gnt = 1'b1;
            end
        end
    end

    assign cpu_gnt   = w_cpu_gnt;
    assign ext_gnt   = w_ext_gnt;
    // The pipeline freezes whenever it asks but loses, never during reset.
    assign cpu_stall = ~srst & cpu_req & ~w_cpu_gnt;

    // Steer the granted requester onto the SRAM port; idle port is all-zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wen   = cpu_wen;
            mem_ren   = ~cpu_wen;
        end else if (w_ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_wen   = ext_wen;
            mem_ren   = ~ext_wen;
        end
    end

    // Next-state for the starvation counter and the read-return tracker.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        rd_pend_d    = 1'b0;
        rd_owner_d   = rd_owner_q;

        // Counter restarts whenever the host is served or stops asking,
        // otherwise it counts denied cycles up to the forcing threshold.
        if (w_ext_gnt || !ext_req) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != c_STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        w_rd_grant = (w_cpu_gnt & ~cpu_wen) | (w_ext_gnt & ~ext_wen);
        if (w_rd_grant) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = w_ext_gnt ? c_OWNER_EXT : c_OWNER_CPU;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            starve_cnt_q <= 4'd0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= c_OWNER_CPU;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Route the returning read data to its owner; the other side sees zero.
    // Returns are suppressed while reset is held so every output is quiet.
    always_comb begin
        w_rd_cpu   = ~srst & rd_pend_q & (rd_owner_q == c_OWNER_CPU);
        w_rd_ext   = ~srst & rd_pend_q & (rd_owner_q == c_OWNER_EXT);
        cpu_rvalid = w_rd_cpu;
        ext_rvalid = w_rd_ext;
        cpu_rdata  = w_rd_cpu ? mem_rdata : '0;
        ext_rdata  = w_rd_ext ? mem_rdata : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Scoreboard testbench for dmem_arbiter. Directed vectors
//                carry hand-computed grants and read returns; a monitor
//                compares every cycle against the queued expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              srst;
    logic              cpu_req, cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ext_req, ext_wen;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt, ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen, mem_ren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .srst       (srst),
        .cpu_req    (cpu_req),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ext_req    (ext_req),
        .ext_wen    (ext_wen),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        cg, eg, stall, ren, wen, crv, erv;
        logic [63:0] addr, wdata, crd, erd;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", tag, name, act, exp);
        end
    endtask

    // Monitor: compares every cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, "cpu_gnt",    64'(cpu_gnt),    64'(e.cg));
            chk(e.tag, "ext_gnt",    64'(ext_gnt),    64'(e.eg));
            chk(e.tag, "cpu_stall",  64'(cpu_stall),  64'(e.stall));
            chk(e.tag, "mem_ren",    64'(mem_ren),    64'(e.ren));
            chk(e.tag, "mem_wen",    64'(mem_wen),    64'(e.wen));
            chk(e.tag, "mem_addr",   mem_addr,        e.addr);
            chk(e.tag, "mem_wdata",  mem_wdata,       e.wdata);
            chk(e.tag, "cpu_rvalid", 64'(cpu_rvalid), 64'(e.crv));
            chk(e.tag, "ext_rvalid", 64'(ext_rvalid), 64'(e.erv));
            chk(e.tag, "cpu_rdata",  cpu_rdata,       e.crd);
            chk(e.tag, "ext_rdata",  ext_rdata,       e.erd);
        end
    end

    // One cycle of stimulus plus its hand-computed expected response.
    task automatic step(input string tag, input logic rst,
                        input logic creq, input logic cwen,
                        input logic [63:0] caddr, input logic [63:0] cwd,
                        input logic ereq, input logic ewen,
                        input logic [63:0] eaddr, input logic [63:0] ewd,
                        input logic [63:0] rdata,
                        input logic xcg, input logic xeg,
                        input logic xcrv, input logic xerv);
        exp_t e;
        @(posedge clk);
        #1;
        srst      = rst;
        cpu_req   = creq;  cpu_wen = cwen;  cpu_addr = caddr;  cpu_wdata = cwd;
        ext_req   = ereq;  ext_wen = ewen;  ext_addr = eaddr;  ext_wdata = ewd;
        mem_rdata = rdata;
        e.tag   = tag;
        e.cg    = xcg;
        e.eg    = xeg;
        e.stall = ~rst & creq & ~xcg;
        e.addr  = xcg ? caddr : (xeg ? eaddr : 64'd0);
        e.wdata = xcg ? cwd   : (xeg ? ewd   : 64'd0);
        e.wen   = (xcg & cwen)  | (xeg & ewen);
        e.ren   = (xcg & ~cwen) | (xeg & ~ewen);
        e.crv   = xcrv;
        e.erv   = xerv;
        e.crd   = xcrv ? rdata : 64'd0;
        e.erd   = xerv ? rdata : 64'd0;
        sb.push_back(e);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0,0,0,0, 0,0,0,0, 64'h0, 0,0, 0,0);
    endtask

    initial begin
        srst = 1'b1;
        cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_wen = 0; ext_addr = '0; ext_wdata = '0;
        mem_rdata = '0;

        // Reset: requests present but everything held at zero.
        step("rst0", 1, 1,0,64'h8,64'h1, 1,1,64'h9,64'h2, 64'h55, 0,0, 0,0);
        step("rst1", 1, 1,1,64'h8,64'h1, 1,0,64'h9,64'h2, 64'h55, 0,0, 0,0);
        idle("idle0");

        // Single CPU read, data back next cycle.
        step("cpurd",  0, 1,0,64'h10,64'h0, 0,0,64'h0,64'h0, 64'h0, 1,0, 0,0);
        step("cpuret", 0, 0,0,64'h0,64'h0,  0,0,64'h0,64'h0, 64'hDEAD_BEEF, 0,0, 1,0);

        // Host write with CPU idle; no return afterwards.
        step("extwr",  0, 0,0,64'h0,64'h0, 1,1,64'h20,64'h1234, 64'h0, 0,1, 0,0);
        step("extwr1", 0, 0,0,64'h0,64'h0, 0,0,64'h0,64'h0, 64'h77, 0,0, 0,0);

        // Continuous contention (writes): CPU x4, host, CPU x4, host.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++)
                step("starve_cpu", 0, 1,1,64'h40+64'(i),64'h100+64'(i),
                     1,1,64'h80,64'hE0, 64'h0, 1,0, 0,0);
            step("starve_ext", 0, 1,1,64'h44,64'h104, 1,1,64'h80,64'hE0,
                 64'h0, 0,1, 0,0);
        end
        idle("idle1");

        // Alternating CPU read then host read; returns in order, never together.
        step("alt0", 0, 1,0,64'h100,64'h0, 0,0,64'h0,64'h0,   64'h0,    1,0, 0,0);
        step("alt1", 0, 0,0,64'h0,64'h0,   1,0,64'h200,64'h0, 64'hAAAA, 0,1, 1,0);
        step("alt2", 0, 0,0,64'h0,64'h0,   0,0,64'h0,64'h0,   64'hBBBB, 0,0, 0,1);
        idle("idle2");

        // Host read then reset: the return is dropped, all outputs quiet.
        step("rrd",  0, 0,0,64'h0,64'h0,  1,0,64'h300,64'h0, 64'h0,    0,1, 0,0);
        step("rrs0", 1, 1,0,64'h8,64'h0,  1,0,64'h300,64'h0, 64'hCCCC, 0,0, 0,0);
        step("rrs1", 1, 1,0,64'h8,64'h0,  1,0,64'h300,64'h0, 64'hCCCC, 0,0, 0,0);
        step("rrs2", 0, 0,0,64'h0,64'h0,  0,0,64'h0,64'h0,   64'hCCCC, 0,0, 0,0);
        // Counter starts at zero after reset: four CPU wins, then the host.
        for (int i = 0; i < 4; i++)
            step("post_rst_cpu", 0, 1,1,64'h50,64'h5, 1,1,64'h60,64'h6, 64'h0, 1,0, 0,0);
        step("post_rst_ext", 0, 1,1,64'h50,64'h5, 1,1,64'h60,64'h6, 64'h0, 0,1, 0,0);
        idle("idle3");

        // Host waits 3, drops 1, re-asserts: needs 4 more denials.
        for (int i = 0; i < 3; i++)
            step("drop_wait", 0, 1,1,64'h70,64'h7, 1,1,64'h90,64'h9, 64'h0, 1,0, 0,0);
        step("drop_gap", 0, 1,1,64'h70,64'h7, 0,0,64'h0,64'h0, 64'h0, 1,0, 0,0);
        for (int i = 0; i < 4; i++)
            step("drop_rewait", 0, 1,1,64'h70,64'h7, 1,1,64'h90,64'h9, 64'h0, 1,0, 0,0);
        step("drop_ext", 0, 1,1,64'h70,64'h7, 1,1,64'h90,64'h9, 64'h0, 0,1, 0,0);
        idle("idle4");

        // Drain scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port arbiter that shares the processor's 64-bit data memory between the MEM pipeline stage and the external host port. It sits between those two requesters and the data SRAM. The MEM stage has priority, and a starvation counter guarantees host progress. Read data returns one cycle after the grant and is routed back to the requester that issued the read; the MEM stage is stalled whenever it requests but is not granted.

## Interface
Parameters:
- ADDR_W, 64, byte address width of both requesters and memory
- DATA_W, 64, data word width
- STARVE_MAX, 4, consecutive denied host-request cycles before the host is forced through (1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- srst  in  1  reset; synchronous, active-high
- cpu_req  in  1  MEM-stage access request; held with stable payload until cpu_gnt
- cpu_wen  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  MEM-stage address
- cpu_wdata  in  DATA_W  MEM-stage write data
- cpu_gnt  out  1  MEM-stage request accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline registers
- cpu_rvalid  out  1  cpu_rdata valid (cycle after a granted CPU read)
- cpu_rdata  out  DATA_W  read data to the MEM stage
- ext_req, ext_wen, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  host request, same rules as the CPU port
- ext_gnt  out  1  host request accepted this cycle
- ext_rvalid  out  1  ext_rdata valid
- ext_rdata  out  DATA_W  read data to the host
- mem_addr  out  ADDR_W  SRAM address
- mem_wen  out  1  SRAM write enable
- mem_ren  out  1  SRAM read enable
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_ren

## Operation
- The grant is combinational from the current requests and registered state. At most one grant is issued per cycle. One grant = one transfer.
- Grant rule, in priority order:
  - ext_req & (starve_cnt == STARVE_MAX) -> ext_gnt
  - else cpu_req -> cpu_gnt
  - else ext_req -> ext_gnt
  - else no grant
- starve_cnt register (4 bits):
  - cleared when ext_gnt or ~ext_req
  - incremented when ext_req & ~ext_gnt
  - saturates at STARVE_MAX
- Memory drive: the granted requester's addr/wdata are passed to mem_*. mem_wen = gnt & wen. mem_ren = gnt & ~wen. With no grant, mem_wen = mem_ren = 0 and addr/wdata = 0.
- Read return tracking (rd_pend, rd_owner registers):
  - On a granted read: rd_pend <= 1, rd_owner <= 0 for CPU, 1 for EXT. Otherwise rd_pend <= 0.
  - Next cycle: the selected *_rvalid = rd_pend and the selected *_rdata = mem_rdata. The non-selected rdata is driven 0.
- A write is complete at its grant edge. No rvalid is issued for writes.
- Back-to-back grants to the same or alternating requesters are allowed every cycle. A read grant may overlap the previous read's return.

## Timing
- Reset values: starve_cnt = 0, rd_pend = 0, rd_owner = 0.
  - All registered outputs are 0: cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata.
  - Grants and mem_* follow the combinational rules, but are forced to 0 while srst = 1.
- Latency:
  - Grant: 0 cycles from req, when not blocked.
  - Read data: exactly 1 cycle after the grant.
  - Worst-case host wait: STARVE_MAX cycles under continuous cpu_req.
- Simultaneous requests with starve_cnt < STARVE_MAX: CPU wins, host counter increments.
- Simultaneous requests with starve_cnt == STARVE_MAX: host wins, cpu_stall = 1 for that cycle, counter clears next edge.
- Reset asserted the cycle after a granted read: rd_pend clears, so no rvalid is issued for that read.
- ext_req dropping before its grant clears starve_cnt. This is not an error.
- Address and data are not checked; width and alignment are the requester's responsibility.

## Test plan
- Single CPU read of addr 0x10, with mem returning 0xDEAD_BEEF -> cpu_gnt in the same cycle, mem_ren = 1. Next cycle: cpu_rvalid = 1, cpu_rdata = 0xDEAD_BEEF, ext_rvalid = 0.
- Host write of addr 0x20, data 0x1234 with CPU idle -> ext_gnt = 1, mem_wen = 1, mem_addr = 0x20, mem_wdata = 0x1234, no rvalid.
- Continuous cpu_req and ext_req with STARVE_MAX = 4 -> CPU granted cycles 0–3. Host granted cycle 4 with cpu_stall = 1. CPU granted cycles 5–8, host cycle 9. The pattern repeats.
- Alternating CPU read then host read in consecutive cycles -> cpu_rvalid in cycle 1 with the first data, ext_rvalid in cycle 2 with the second data. Never both in one cycle.
- Host read granted, srst = 1 on the next edge -> no ext_rvalid. All outputs 0 while reset is asserted. starve_cnt is 0 after reset.
- ext_req held 3 cycles against the CPU, then dropped for 1 cycle and reasserted -> the counter restarts from 0, and the host is granted only after 4 further denied cycles.
